// File: rtl/keycode_tracker.sv
// keycode_tracker: per-frame keyboard state tracker.
// Matches every keycode slot against a table of tracked keys. Samples the result
// once per video frame, on the rising edge of frame_clk after synchronisation.
// For each tracked key it produces a held level plus one-cycle press, release
// and auto-repeat pulses.
// Optional feature macro: KEYTRACK_REPEAT_EN
//   defined     -> per-key repeat FSMs and frame counters are built.
//   not defined -> repeat_pulse is tied to 0.
module keycode_tracker #(
    parameter int              SLOTS        = 4,
    parameter int              KEYS         = 4,
    parameter logic [KEYS*8-1:0] KEY_CODES  = {8'h2C, 8'h07, 8'h04, 8'h1A},
    parameter int              REPEAT_DELAY = 30,
    parameter int              REPEAT_RATE  = 6,
    parameter int              CNT_W        = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [8*SLOTS-1:0]   keycode,
    input  logic                 frame_clk,
    output logic                 frame_tick,
    output logic [KEYS-1:0]      held,
    output logic [KEYS-1:0]      pressed,
    output logic [KEYS-1:0]      released,
    output logic [KEYS-1:0]      repeat_pulse,
    output logic                 any_held
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;

    logic            s1_reg, s2_reg, s3_reg;
    logic [KEYS-1:0] match;
    logic [KEYS-1:0] held_reg, pressed_reg, released_reg;

    // Synchronise frame_clk and keep the previous level for edge detection.
    // Resetting to 1 means a frame_clk that is already high at reset release
    // does not produce a tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_reg <= 1'b1;
            s2_reg <= 1'b1;
            s3_reg <= 1'b1;
        end else begin
            s1_reg <= frame_clk;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign frame_tick = s2_reg & ~s3_reg;

    // Per-key match: any slot equal to the key code. A zero code disables the key,
    // so empty (zero) slots never match.
    genvar gi, gj;
    generate
        for (gi = 0; gi < KEYS; gi++) begin : g_match
            localparam logic [7:0] CODE = KEY_CODES[8*gi +: 8];
            logic [SLOTS-1:0] hit;
            for (gj = 0; gj < SLOTS; gj++) begin : g_slot
                assign hit[gj] = (keycode[8*gj +: 8] == CODE) && (CODE != 8'h00);
            end
            assign match[gi] = |hit;
        end
    endgenerate

    // Frame sample: update levels and edge pulses on the tick. Pulses clear on every other edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            held_reg     <= '0;
            pressed_reg  <= '0;
            released_reg <= '0;
        end else if (frame_tick) begin
            held_reg     <= match;
            pressed_reg  <= match & ~held_reg;
            released_reg <= ~match & held_reg;
        end else begin
            pressed_reg  <= '0;
            released_reg <= '0;
        end
    end

    assign held     = held_reg;
    assign pressed  = pressed_reg;
    assign released = released_reg;
    assign any_held = |held_reg;

    // Reachable only for a configuration whose counter cannot hold the repeat targets.
    generate
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || CNT_W < $clog2(CNT_MAX + 1)) begin : g_bad_config
        end
    endgenerate

`ifdef KEYTRACK_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    generate
        for (gi = 0; gi < KEYS; gi++) begin : g_repeat
            rep_state_t       state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             rep_reg;

            // Per-key repeat FSM. It advances only on frame ticks, and its pulse is one cycle wide.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    rep_reg   <= 1'b0;
                end else begin
                    rep_reg <= 1'b0;
                    if (frame_tick) begin
                        case (state_reg)
                            ST_IDLE: begin
                                if (match[gi]) begin
                                    state_reg <= ST_DELAY;
                                    cnt_reg   <= CNT_W'(1);
                                end
                            end
                            ST_DELAY: begin
                                if (!match[gi]) begin
                                    state_reg <= ST_IDLE;
                                    cnt_reg   <= '0;
                                end else if (cnt_reg == CNT_W'(REPEAT_DELAY)) begin
                                    rep_reg   <= 1'b1;
                                    state_reg <= ST_REPEAT;
                                    cnt_reg   <= CNT_W'(1);
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_W'(1);
                                end
                            end
                            ST_REPEAT: begin
                                if (!match[gi]) begin
                                    state_reg <= ST_IDLE;
                                    cnt_reg   <= '0;
                                end else if (cnt_reg == CNT_W'(REPEAT_RATE)) begin
                                    rep_reg <= 1'b1;
                                    cnt_reg <= CNT_W'(1);
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_W'(1);
                                end
                            end
                            default: begin
                                state_reg <= ST_IDLE;
                                cnt_reg   <= '0;
                            end
                        endcase
                    end
                end
            end

            assign repeat_pulse[gi] = rep_reg;
        end
    endgenerate
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_keycode_tracker.sv
// Testbench for keycode_tracker: directed steps followed by random frames.
// A frame-level reference model tracks, for each key, how many consecutive
// frames it has been sampled down. Press, release and repeat expectations
// follow from that count.
module tb_keycode_tracker;

    localparam int D = 3;
    localparam int R = 2;
`ifdef KEYTRACK_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] keycode;
    logic        frame_clk;
    logic        frame_tick;
    logic [3:0]  held, pressed, released, repeat_pulse;
    logic        any_held;

    int compared   = 0;
    int mismatched = 0;
    int hcnt [4];
    bit prev [4];
    logic [7:0] codes [4] = '{8'h1A, 8'h04, 8'h07, 8'h2C};
    int rep_seen0 = 0;
    logic [31:0] kc_cur;

    keycode_tracker #(
        .SLOTS(4), .KEYS(4), .KEY_CODES({8'h2C, 8'h07, 8'h04, 8'h1A}),
        .REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(8)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
        .frame_tick(frame_tick), .held(held), .pressed(pressed), .released(released),
        .repeat_pulse(repeat_pulse), .any_held(any_held)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            hcnt[k] = 0;
            prev[k] = 1'b0;
        end
    endtask

    // Reference model for one frame sample.
    task automatic model_frame(input logic [31:0] kc, output logic [3:0] eh,
                               output logic [3:0] ep, output logic [3:0] er,
                               output logic [3:0] erp);
        for (int k = 0; k < 4; k++) begin
            bit m = 1'b0;
            for (int j = 0; j < 4; j++)
                if (kc[8*j +: 8] == codes[k] && codes[k] != 8'h00) m = 1'b1;
            ep[k]  = m && !prev[k];
            er[k]  = !m && prev[k];
            hcnt[k] = m ? hcnt[k] + 1 : 0;
            erp[k] = REP_EN && m && (hcnt[k] > D) && (((hcnt[k] - 1 - D) % R) == 0);
            eh[k]  = m;
            prev[k] = m;
        end
    endtask

    // One frame: apply keycode, raise frame_clk, then check the tick and the outputs.
    task automatic do_frame(input logic [31:0] kc);
        logic [3:0] eh, ep, er, erp;
        @(negedge Clk);
        keycode   = kc;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk);            // s1 samples high
        @(posedge Clk); #1;        // s2 high: tick cycle
        chk("tick_high", frame_tick, 1'b1);
        model_frame(kc, eh, ep, er, erp);
        @(posedge Clk); #1;        // edge ending the tick cycle
        chk("tick_low", frame_tick, 1'b0);
        chk("held", held, eh);
        chk("pressed", pressed, ep);
        chk("released", released, er);
        chk("repeat", repeat_pulse, erp);
        chk("any_held", any_held, |eh);
        rep_seen0 += int'(repeat_pulse[0]);
        $display("frame kc=%h held=%b pressed=%b released=%b repeat=%b", kc, held, pressed, released, repeat_pulse);
        @(posedge Clk); #1;
        chk("pulses_clear", {pressed, released, repeat_pulse}, 12'h000);
        chk("held_persist", held, eh);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h1A;
            2:       return 8'h04;
            3:       return 8'h07;
            4:       return 8'h2C;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        // Reset with frame_clk high and a tracked key already down.
        model_reset();
        Reset_n   = 1'b0;
        frame_clk = 1'b1;
        keycode   = 32'h0000001A;
        repeat (3) @(negedge Clk);
        chk("rst_outputs", {frame_tick, held, pressed, released, repeat_pulse, any_held}, 18'h0);
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            chk("no_tick_after_rst", frame_tick, 1'b0);
            chk("idle_after_rst", {held, pressed, released, repeat_pulse}, 16'h0);
        end

        // Single press and release.
        do_frame(32'h0000001A);
        do_frame(32'h0000001A);
        do_frame(32'h0000001A);
        do_frame(32'h00000000);

        // Multi-slot, then duplicate slots.
        do_frame(32'h2C07041A);
        chk("multi_held", held, 4'hF);
        do_frame(32'h1A1A0000);
        do_frame(32'h00000000);

        // Repeat cadence over ten held frames.
        rep_seen0 = 0;
        for (int i = 0; i < 10; i++) do_frame(32'h0000001A);
        chk("repeat_count_10", rep_seen0, REP_EN ? 4 : 0);
        do_frame(32'h00000000);
        rep_seen0 = 0;
        for (int i = 0; i < 4; i++) do_frame(32'h0000001A);
        do_frame(32'h00000000);
        chk("repeat_count_4", rep_seen0, REP_EN ? 1 : 0);

        // Sub-frame glitch: the keycode changes only between ticks.
        @(negedge Clk);
        frame_clk = 1'b0;
        keycode   = 32'h00000004;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            chk("glitch_tick", frame_tick, 1'b0);
            chk("glitch_outputs", {held, pressed, released}, 12'h0);
        end
        @(negedge Clk);
        keycode = 32'h00000000;
        do_frame(32'h00000000);

        // Mid-operation reset while the key is in the repeat phase.
        for (int i = 0; i < 6; i++) do_frame(32'h0000001A);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {frame_tick, held, pressed, released, repeat_pulse, any_held}, 18'h0);
        model_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        rep_seen0 = 0;
        for (int i = 0; i < 4; i++) do_frame(32'h0000001A);
        chk("midrst_repeat_count", rep_seen0, REP_EN ? 1 : 0);
        do_frame(32'h00000000);

        // Random frames; slots tend to persist, so repeats occur.
        kc_cur = 32'h0;
        for (int f = 0; f < 80; f++) begin
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 9) >= 7) kc_cur[8*j +: 8] = pick();
            do_frame(kc_cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
